// File: rtl/relu_pool22_pkg.sv
// +--------------------------------------------------------------------------+
// | relu_pool22_pkg : shared CNN constants and pooling row-FSM encoding       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package relu_pool22_pkg;

  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_OUT_WIDTH = 32;
  localparam int DEF_IMG_W     = 24;
  localparam int DEF_IMG_H     = 24;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ROW_FILL = 2'd0;
  localparam logic [STATE_W-1:0] ROW_EMIT = 2'd1;
  localparam logic [STATE_W-1:0] ROW_DROP = 2'd2;

  // Index width that still yields one bit for degenerate sizes.
  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/relu_pool22_row_buf.sv
// +--------------------------------------------------------------------------+
// | pool_row_buf : horizontal-max line buffer, one write / one async read     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module pool_row_buf
  import relu_pool22_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W / 2,
  parameter int WIDTH = DEF_BIT_WIDTH,
  parameter int AW    = addr_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are never reset: every entry is written on the fill row first.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/relu_pool22.sv
// +--------------------------------------------------------------------------+
// | relu_pool22 : shift + ReLU + 2x2 max-pool on a raster pixel stream.       |
// | Optional macro RELU_POOL_SAT_EN clips instead of wrapping.  Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module relu_pool22
  import relu_pool22_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int SHIFT     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [OUT_WIDTH-1:0] convValue,
  output logic                        pool_valid,
  output logic signed [BIT_WIDTH-1:0] pool_out,
  output logic                        frame_done
);

  localparam int CW    = addr_bits(IMG_W);
  localparam int RW    = addr_bits(IMG_H);
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = addr_bits(DEPTH);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_PEN  = RW'(IMG_H - 2);

  logic [CW-1:0]               col;
  logic [RW-1:0]               row;
  logic [STATE_W-1:0]          state;
  logic [BIT_WIDTH-1:0]        held;

  logic signed [OUT_WIDTH-1:0] q;
  logic signed [OUT_WIDTH-1:0] r;
  logic [BIT_WIDTH-1:0]        pix;
  logic [BIT_WIDTH-1:0]        h;
  logic [BIT_WIDTH-1:0]        buf_rd;
  logic [BIT_WIDTH-1:0]        pooled;
  logic [AW-1:0]               pair;
  logic                        buf_we;
  logic                        last_col;
  logic                        last_row;

  assign q = convValue >>> SHIFT;
  assign r = q[OUT_WIDTH-1] ? '0 : q;

`ifdef RELU_POOL_SAT_EN
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);
  assign pix = ($unsigned(r) > SAT_MAX) ? SAT_MAX[BIT_WIDTH-1:0] : r[BIT_WIDTH-1:0];
`else
  logic unused_hi;
  assign pix       = r[BIT_WIDTH-1:0];
  assign unused_hi = ^r[OUT_WIDTH-1:BIT_WIDTH];
`endif

  // r is never negative, so magnitudes compare as unsigned.
  assign h        = (held > pix) ? held : pix;
  assign pooled   = (buf_rd > h) ? buf_rd : h;
  assign pair     = AW'(col >> 1);
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);
  assign buf_we   = en && col[0] && (state == ROW_FILL);

  pool_row_buf #(
    .DEPTH (DEPTH),
    .WIDTH (BIT_WIDTH),
    .AW    (AW)
  ) u_row_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (pair),
    .wdata (h),
    .raddr (pair),
    .rdata (buf_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      state      <= ROW_FILL;
      held       <= '0;
      pool_valid <= 1'b0;
      pool_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
      if (en) begin
        if (!col[0]) begin
          held <= pix;
        end
        if (col[0] && (state == ROW_EMIT)) begin
          pool_valid <= 1'b1;
          pool_out   <= $signed(pooled);
        end
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row        <= '0;
            state      <= ROW_FILL;
            frame_done <= 1'b1;
          end else begin
            row <= row + RW'(1);
            case (state)
              ROW_FILL: state <= ROW_EMIT;
              // Odd IMG_H leaves one unpaired row after this emit row.
              ROW_EMIT: state <= (row == ROW_PEN) ? ROW_DROP : ROW_FILL;
              default:  state <= ROW_FILL;
            endcase
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_relu_pool22.sv
// +--------------------------------------------------------------------------+
// | tb_relu_pool22 : scoreboard bench for relu_pool22 (4x2 and 5x5 frames)    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_relu_pool22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               en_a = 1'b0;
  logic signed [31:0] cv_a = '0;
  logic               pv_a;
  logic signed [7:0]  po_a;
  logic               fd_a;

  logic               en_b = 1'b0;
  logic signed [31:0] cv_b = '0;
  logic               pv_b;
  logic signed [7:0]  po_b;
  logic               fd_b;

  relu_pool22 #(
    .BIT_WIDTH (8), .OUT_WIDTH (32), .IMG_W (4), .IMG_H (2), .SHIFT (0)
  ) u_a (
    .clk (clk), .rst (rst), .en (en_a), .convValue (cv_a),
    .pool_valid (pv_a), .pool_out (po_a), .frame_done (fd_a)
  );

  relu_pool22 #(
    .BIT_WIDTH (8), .OUT_WIDTH (32), .IMG_W (5), .IMG_H (5), .SHIFT (0)
  ) u_b (
    .clk (clk), .rst (rst), .en (en_b), .convValue (cv_b),
    .pool_valid (pv_b), .pool_out (po_b), .frame_done (fd_b)
  );

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   fqa[$];
  int   fqb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   pa[8];
  int   sat_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a pulse.
  always @(negedge clk) begin
    exp_t e;
    int   f;
    if (pv_a) begin
      if (qa.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_pool_out", int'(po_a), e.val);
        check("a_pool_cycle", cyc, e.cyc);
      end
    end
    if (fd_a) begin
      if (fqa.size() == 0) check("a_unexpected_frame_done", 1, 0);
      else begin
        f = fqa.pop_front();
        check("a_frame_done_cycle", cyc, f);
      end
    end
    if (pv_b) begin
      if (qb.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_pool_out", int'(po_b), e.val);
        check("b_pool_cycle", cyc, e.cyc);
      end
    end
    if (fd_b) begin
      if (fqb.size() == 0) check("b_unexpected_frame_done", 1, 0);
      else begin
        f = fqb.pop_front();
        check("b_frame_done_cycle", cyc, f);
      end
    end
  end

  task automatic drive_a(input int v, input bit pushv, input int ev, input bit pushf);
    @(posedge clk); #1;
    en_a = 1'b1;
    cv_a = v;
    if (pushv) qa.push_back('{val: ev, cyc: cyc + 1});
    if (pushf) fqa.push_back(cyc + 1);
  endtask

  task automatic idle_a();
    @(posedge clk); #1;
    en_a = 1'b0;
    cv_a = $signed($urandom);
  endtask

  task automatic drive_b(input int v, input bit pushv, input int ev, input bit pushf);
    @(posedge clk); #1;
    en_b = 1'b1;
    cv_b = v;
    if (pushv) qb.push_back('{val: ev, cyc: cyc + 1});
    if (pushf) fqb.push_back(cyc + 1);
  endtask

  task automatic idle_b();
    @(posedge clk); #1;
    en_b = 1'b0;
    cv_b = $signed($urandom);
  endtask

  // One 4x2 frame from pa[]; outputs follow pixels 5 and 7 (odd row, odd cols).
  task automatic frame_a(input int e0, input int e1, input bit tog);
    for (int i = 0; i < 8; i++) begin
      if (tog) idle_a();
      drive_a(pa[i], (i == 5) || (i == 7), (i == 5) ? e0 : e1, i == 7);
    end
    idle_a();
  endtask

  task automatic reset_check();
    check("a_rst_valid", int'(pv_a), 0);
    check("a_rst_out", int'(po_a), 0);
    check("a_rst_frame_done", int'(fd_a), 0);
    check("b_rst_valid", int'(pv_b), 0);
    check("b_rst_out", int'(po_b), 0);
    check("b_rst_frame_done", int'(fd_b), 0);
  endtask

  initial begin
    int eb[4];
    int k;
`ifdef RELU_POOL_SAT_EN
    sat_val = 127;
`else
    sat_val = 44;
`endif
    repeat (2) @(negedge clk);
    reset_check();
    @(posedge clk); #1;
    rst = 1'b1;

    pa = '{1, 5, 2, 3, 4, 0, 7, 6};
    frame_a(5, 7, 1'b0);
    frame_a(5, 7, 1'b1);

    pa = '{-100, -100, -100, -100, -100, -100, -100, -100};
    frame_a(0, 0, 1'b0);

    pa = '{300, 300, 300, 300, 300, 300, 300, 300};
    frame_a(sat_val, sat_val, 1'b0);

    pa = '{-5, 3, -7, -1, 2, -4, 8, -9};
    frame_a(3, 8, 1'b0);

    // Reset lands while the 6th pixel is presented: it must never emit.
    pa = '{1, 5, 2, 3, 4, 0, 7, 6};
    for (int i = 0; i < 5; i++) drive_a(pa[i], 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    en_a = 1'b1;
    cv_a = pa[5];
    #2 rst = 1'b0;
    @(negedge clk);
    reset_check();
    en_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    pa = '{9, 2, 1, 4, 3, 8, 6, 5};
    frame_a(9, 6, 1'b0);

    // 5x5: last column and row carry 100 and must be ignored.
    eb = '{11, 13, 31, 33};
    k = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if ((r % 2 == 1) && (c % 2 == 1) && (r < 4) && (c < 4)) begin
          drive_b((r < 4 && c < 4) ? r * 10 + c : 100, 1'b1, eb[k], 1'b0);
          k++;
        end else begin
          drive_b((r < 4 && c < 4) ? r * 10 + c : 100, 1'b0, 0, (r == 4) && (c == 4));
        end
      end
    end
    idle_b();

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("a_outputs_left", qa.size(), 0);
    check("a_frame_done_left", fqa.size(), 0);
    check("b_outputs_left", qb.size(), 0);
    check("b_frame_done_left", fqb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
